// File: rtl/hog_pix_feeder_pkg.sv
// rtl/hog_pix_feeder_pkg.sv - shared feeder state encoding and default pixel/memory geometry
package hog_pix_feeder_pkg;

  localparam int DEF_PIX_W = 8;
  localparam int DEF_PIX_N = 96;
  localparam int DEF_MEM_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } feed_state_t;

endpackage

// File: rtl/hog_pix_feeder.sv
// rtl/hog_pix_feeder.sv - fetches memory words and assembles them into pixel bundles for the HOG core
module hog_pix_feeder
  import hog_pix_feeder_pkg::*;
#(
  parameter int PIX_W       = DEF_PIX_W,
  parameter int PIX_N       = DEF_PIX_N,
  parameter int MEM_W       = DEF_MEM_W,
  parameter int MADDR_W     = 16,
  parameter int FRAME_WORDS = 38400
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   request,
  output logic                   ready,
  output logic [PIX_W*PIX_N-1:0] o_data,
  output logic                   mem_rd,
  output logic [MADDR_W-1:0]     mem_addr,
  input  logic [MEM_W-1:0]       mem_rdata,
  input  logic                   mem_valid,
  output logic                   frame_done
);

  localparam int BUS_W = PIX_W * PIX_N;
  localparam int WPR   = BUS_W / MEM_W;
  localparam int W_W   = (WPR > 1) ? $clog2(WPR) : 1;

  localparam logic [W_W-1:0]     W_LAST   = W_W'(WPR - 1);
  localparam logic [MADDR_W-1:0] PTR_LAST = MADDR_W'(FRAME_WORDS - 1);

  feed_state_t          state, state_nxt;
  logic [MADDR_W-1:0]   ptr;
  logic [W_W-1:0]       w;
  logic                 pending;
  logic [BUS_W-1:0]     asm_q;

  assign mem_addr = ptr;

  // Next-state and read-strobe decode; only one read is in flight, so WAIT gates mem_valid
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    case (state)
      ST_IDLE:    if (request || pending) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        mem_rd    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT:    if (mem_valid) state_nxt = (w == W_LAST) ? ST_DELIVER : ST_ISSUE;
      ST_DELIVER: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Pending request latch: one-deep, consumed when IDLE launches a fetch
  always_ff @(posedge clk) begin
    if (rst)                                            pending <= 1'b0;
    else if (state == ST_IDLE && state_nxt == ST_ISSUE) pending <= 1'b0;
    else if (state != ST_IDLE && request)               pending <= 1'b1;
  end

  // Word capture, frame pointer and slot counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      w     <= '0;
      asm_q <= '0;
    end else if (state == ST_WAIT && mem_valid) begin
      asm_q[w*MEM_W +: MEM_W] <= mem_rdata;
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + MADDR_W'(1);
      w   <= (w == W_LAST) ? '0 : w + W_W'(1);
    end else if (state == ST_DELIVER) begin
      w <= '0;
    end
  end

  // Bundle output; pointer back at 0 during DELIVER means the frame's last word was just taken
  always_ff @(posedge clk) begin
    if (rst) begin
      ready      <= 1'b0;
      frame_done <= 1'b0;
      o_data     <= '0;
    end else begin
      ready      <= (state == ST_DELIVER);
      frame_done <= (state == ST_DELIVER) && (ptr == '0);
      if (state == ST_DELIVER) o_data <= asm_q;
    end
  end

endmodule
